display_clock_supervisor: RTL
=============================

// Module: display_clock_supervisor
// PURPOSE
// Controls and checks the display MMCM that makes the pixel (1x) and SerDes (5x) clocks.
// - Drives the MMCM reset and watches its LOCKED output.
// - Requires lock to stay stable for a set time before it reports the display clocks usable.
// - Retries the MMCM on lock timeout or lock loss, and latches a fault when retries run out.
// It runs in the i_clk input-clock domain, between the MMCM and the TMDS/timing reset logic.
// PARAMETERS
// RST_CYCLES    16         cycles o_mmcm_rst is held high per reset attempt (>=1)
// LOCK_TIMEOUT  1_000_000  max cycles to wait for synced lock after reset release (10 ms @100 MHz)
// STABLE_CYCLES 1024       consecutive synced-lock cycles needed before o_clk_ok
// MAX_RETRIES   4          failed attempts (timeout or loss) allowed before FAULT
// CNT_W         8          width of o_loss_count
// PORTS
// i_clk         in   1      input/reference clock (same clock as the MMCM input)
// i_rst_n       in   1      asynchronous active-low reset
// i_locked      in   1      MMCM LOCKED; asynchronous to i_clk
// i_retry       in   1      one-cycle pulse: leave FAULT, or force a fresh attempt from any state
// o_mmcm_rst    out  1      active-high reset to the MMCM
// o_clk_ok      out  1      display clocks stable; downstream resets may release
// o_fault       out  1      retries exhausted (sticky until i_retry)
// o_state       out  3      current FSM state encoding (debug)
// o_loss_count  out  CNT_W  lock losses seen in READY; saturates at all-ones
// BEHAVIOUR
// Reset values (i_rst_n low):
// - state = RESET, o_mmcm_rst = 1, o_clk_ok = 0, o_fault = 0.
// - o_loss_count = 0, retry count = 0, sync flops = 0.
// Lock synchronizer: 2-flop synchronizer on i_locked gives lock_s; 2-cycle latency; all decisions use lock_s.
// The cycle counter is shared by all states, sized $clog2 of the largest parameter, and cleared on every state change.
// FSM states:
// - RESET: o_mmcm_rst = 1. After RST_CYCLES cycles, go to WAIT_LOCK.
// - WAIT_LOCK: o_mmcm_rst = 0.
//   - lock_s = 1: go to SETTLE.
//   - counter reaches LOCK_TIMEOUT-1 while lock_s = 0: this is a failed attempt.
// - SETTLE:
//   - lock_s = 0: failed attempt; the counter restarts on the next entry.
//   - STABLE_CYCLES consecutive lock_s = 1: go to READY and clear the retry count.
// - READY: o_clk_ok = 1, registered, asserted the first cycle in READY.
//   - lock_s = 0: o_clk_ok drops the next cycle, o_loss_count increments (saturating), failed attempt.
// - FAULT: o_fault = 1, o_mmcm_rst = 1 (MMCM held in reset). Only i_retry leaves FAULT.
// Failed attempt: retry count +1. If the new value > MAX_RETRIES go to FAULT, otherwise go to RESET.
// i_retry:
// - In any state it clears the retry count and o_fault and goes to RESET.
// - o_loss_count is preserved.
// - i_retry wins over a same-cycle timeout or lock loss; that event is not counted.
// Lock glitches:
// - A 1-cycle lock_s drop in SETTLE counts as a failure.
// - A lock_s toggle in WAIT_LOCK is caught by SETTLE.
// Async reset mid-operation puts everything back to reset values immediately; o_mmcm_rst rises asynchronously.
// All outputs are registered; there are no combinational paths from input to output.
// STRUCTURE
// Package display_clk_pkg:
// - typedef enum logic [2:0] clk_sup_state_t {RESET, WAIT_LOCK, SETTLE, READY, FAULT}.
// - Default-timing localparams shared with the display clock generator configs.
// Sub-module sync_2ff (generic 2-flop bit synchronizer, async active-low reset); reused by other CDC paths.
// TESTING
// Bench params: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
// 1. Release reset with i_locked=0:
//    - o_mmcm_rst high for exactly 4 cycles.
//    - Raise i_locked 5 cycles later: o_clk_ok rises 2 (sync) + 8 cycles after that, then stays high.
// 2. i_locked held at 0:
//    - Three timeouts, each with a 4-cycle o_mmcm_rst pulse between them.
//    - o_fault = 1 after the third 20-cycle timeout; o_mmcm_rst stays 1.
//    - i_retry pulse: o_fault = 0, a new 4-cycle reset, and a normal lock follows.
// 3. In READY, drop i_locked for 3 cycles:
//    - o_clk_ok falls 3 cycles after the drop (2 sync + 1 register).
//    - o_loss_count 0 -> 1, then a re-lock sequence.
// 4. In SETTLE, a 1-cycle i_locked low glitch at settle count 5 -> RESET; o_clk_ok never asserts in that attempt.
// 5. Force 300 losses with CNT_W=8 -> o_loss_count saturates at 255. Set MAX_RETRIES large for this test.
// 6. Assert i_rst_n low while in READY -> o_clk_ok=0, o_mmcm_rst=1 within the same cycle (async); counters cleared.

Source files
------------

// File: rtl/display_clk_pkg.sv
// Shared types and default timing for the display clock generator and its supervisor.
package display_clk_pkg;

  typedef enum logic [2:0] {
    RESET     = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    READY     = 3'd3,
    FAULT     = 3'd4
  } clk_sup_state_t;

  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 1_000_000;
  localparam int unsigned DEF_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_MAX_RETRIES   = 4;
  localparam int unsigned DEF_CNT_W         = 8;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop single-bit synchronizer with asynchronous active-low reset.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/display_clock_supervisor.sv
// Sequences the display MMCM reset, qualifies LOCKED over time, retries on timeout or
// lock loss and latches a fault once the retry budget is spent.
module display_clock_supervisor
  import display_clk_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_locked,
  input  logic             i_retry,
  output logic             o_mmcm_rst,
  output logic             o_clk_ok,
  output logic             o_fault,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_loss_count
);

  localparam int unsigned CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned TMR_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned RC_W    = $clog2(MAX_RETRIES + 2);

  localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  // The lock sample that moves WAIT_LOCK into SETTLE is the first of the stable run,
  // so SETTLE itself only needs STABLE_CYCLES-1 further locked cycles.
  localparam logic [TMR_W-1:0] SETTLE_LAST  =
    TMR_W'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0);
  localparam logic [RC_W-1:0]  RC_LIMIT     = RC_W'(MAX_RETRIES);

  clk_sup_state_t   r_state;
  logic [TMR_W-1:0] r_cnt;
  logic [RC_W-1:0]  r_retry_cnt;
  logic             r_mmcm_rst;
  logic             r_clk_ok;
  logic             r_fault;
  logic [CNT_W-1:0] r_loss_cnt;

  logic             w_lock_s;
  logic             w_fail;
  logic [RC_W-1:0]  w_rc_next;
  clk_sup_state_t   w_fail_state;

  sync_2ff u_lock_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_locked),
    .o_q     (w_lock_s)
  );

  always_comb begin
    w_rc_next    = r_retry_cnt + 1'b1;
    w_fail_state = (w_rc_next > RC_LIMIT) ? FAULT : RESET;
    w_fail       = 1'b0;
    case (r_state)
      WAIT_LOCK:     w_fail = !w_lock_s && (r_cnt == TIMEOUT_LAST);
      SETTLE, READY: w_fail = !w_lock_s;
      default:       w_fail = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= RESET;
      r_cnt       <= '0;
      r_retry_cnt <= '0;
      r_mmcm_rst  <= 1'b1;
      r_clk_ok    <= 1'b0;
      r_fault     <= 1'b0;
      r_loss_cnt  <= '0;
    end else if (i_retry) begin
      // Operator retry overrides any same-cycle failure, which is then not counted.
      r_state     <= RESET;
      r_cnt       <= '0;
      r_retry_cnt <= '0;
      r_mmcm_rst  <= 1'b1;
      r_clk_ok    <= 1'b0;
      r_fault     <= 1'b0;
    end else if (w_fail) begin
      r_state     <= w_fail_state;
      r_cnt       <= '0;
      r_retry_cnt <= w_rc_next;
      r_mmcm_rst  <= 1'b1;
      r_clk_ok    <= 1'b0;
      r_fault     <= (w_fail_state == FAULT);
      if (r_state == READY && r_loss_cnt != '1) begin
        r_loss_cnt <= r_loss_cnt + 1'b1;
      end
    end else begin
      case (r_state)
        RESET: begin
          if (r_cnt == RST_LAST) begin
            r_state    <= WAIT_LOCK;
            r_cnt      <= '0;
            r_mmcm_rst <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (w_lock_s) begin
            r_state <= SETTLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (r_cnt == SETTLE_LAST) begin
            r_state     <= READY;
            r_cnt       <= '0;
            r_retry_cnt <= '0;
            r_clk_ok    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        READY: begin
          r_clk_ok <= 1'b1;
        end
        FAULT: begin
          r_mmcm_rst <= 1'b1;
          r_fault    <= 1'b1;
        end
        default: begin
          r_state    <= RESET;
          r_cnt      <= '0;
          r_mmcm_rst <= 1'b1;
          r_clk_ok   <= 1'b0;
        end
      endcase
    end
  end

  assign o_mmcm_rst   = r_mmcm_rst;
  assign o_clk_ok     = r_clk_ok;
  assign o_fault      = r_fault;
  assign o_state      = r_state;
  assign o_loss_count = r_loss_cnt;

endmodule
